// File: rtl/dcache_pkg.sv
// Shared configuration for the write-through data cache: default geometry,
// derived address-field widths and FSM state encoding.
package dcache_pkg;

    localparam int DEF_LINES  = 16;
    localparam int DEF_WPL    = 4;
    localparam int DEF_ADDR_W = 32;

    localparam int WORD_W = $clog2(DEF_WPL);
    localparam int IDX_W  = $clog2(DEF_LINES);
    localparam int TAG_W  = DEF_ADDR_W - 2 - WORD_W - IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REFILL = 2'd1;
    localparam logic [1:0] S_WRITE  = 2'd2;

endpackage

// File: rtl/dcache_store.sv
// Tag, valid and data arrays of the direct-mapped cache: combinational read,
// synchronous word write, line validate with tag write, async valid clear.
module dcache_store
    import dcache_pkg::*;
#(
    parameter int LINES    = DEF_LINES,
    parameter int WPL      = DEF_WPL,
    parameter int TAG_BITS = TAG_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(LINES)-1:0] rd_idx,
    input  logic [$clog2(WPL)-1:0]   rd_word,
    output logic [31:0]              rd_data,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic                     rd_valid,
    input  logic                     wr_en,
    input  logic [$clog2(LINES)-1:0] wr_idx,
    input  logic [$clog2(WPL)-1:0]   wr_word,
    input  logic [31:0]              wr_data,
    input  logic                     val_en,
    input  logic [$clog2(LINES)-1:0] val_idx,
    input  logic [TAG_BITS-1:0]      val_tag
);

    logic [31:0]         data_mem [LINES*WPL];
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [LINES-1:0]    valid;

    assign rd_data  = data_mem[{rd_idx, rd_word}];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_valid = valid[rd_idx];

    // Data and tags carry no reset; the valid bits alone decide whether a line counts.
    always_ff @(posedge clk) begin
        if (wr_en)
            data_mem[{wr_idx, wr_word}] <= wr_data;
        if (val_en)
            tag_mem[val_idx] <= val_tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (val_en)
            valid[val_idx] <= 1'b1;
    end

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and a multi-cycle backing memory; misses and all stores stall the pipe.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int LINES  = DEF_LINES,
    parameter int WPL    = DEF_WPL,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    localparam int WORD_BITS = $clog2(WPL);
    localparam int IDX_BITS  = $clog2(LINES);
    localparam int TAG_BITS  = ADDR_W - 2 - WORD_BITS - IDX_BITS;

    logic [1:0]           state;
    logic [WORD_BITS-1:0] cnt;

    logic [WORD_BITS-1:0] word;
    logic [IDX_BITS-1:0]  idx;
    logic [TAG_BITS-1:0]  tag;
    logic [TAG_BITS-1:0]  rd_tag;
    logic                 rd_valid;
    logic                 hit;
    logic                 last;

    logic                 wr_en;
    logic [WORD_BITS-1:0] wr_word;
    logic [31:0]          wr_data;
    logic                 val_en;

    assign word = cpu_addr[2 +: WORD_BITS];
    assign idx  = cpu_addr[2 + WORD_BITS +: IDX_BITS];
    assign tag  = cpu_addr[ADDR_W-1 -: TAG_BITS];
    assign hit  = rd_valid && (rd_tag == tag);
    assign last = (cnt == WORD_BITS'(WPL - 1));

    // cpu_addr is frozen by the stall, so the index doubles as the refill target.
    assign wr_en   = mem_ack && ((state == S_REFILL) || (state == S_WRITE && hit));
    assign wr_word = (state == S_REFILL) ? cnt : word;
    assign wr_data = (state == S_REFILL) ? mem_rdata : cpu_wdata;
    assign val_en  = (state == S_REFILL) && mem_ack && last;

    dcache_store #(
        .LINES    (LINES),
        .WPL      (WPL),
        .TAG_BITS (TAG_BITS)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx),
        .rd_word  (word),
        .rd_data  (cpu_rdata),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_idx   (idx),
        .wr_word  (wr_word),
        .wr_data  (wr_data),
        .val_en   (val_en),
        .val_idx  (idx),
        .val_tag  (tag)
    );

    always_comb begin
        cpu_stall = 1'b0;
        case (state)
            S_IDLE:   cpu_stall = cpu_we || (cpu_re && !hit);
            S_REFILL: cpu_stall = 1'b1;
            S_WRITE:  cpu_stall = !mem_ack;
            default:  cpu_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_we) begin
                        state     <= S_WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cpu_addr & ~ADDR_W'(3);
                        mem_wdata <= cpu_wdata;
                    end else if (cpu_re && !hit) begin
                        state    <= S_REFILL;
                        cnt      <= '0;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[ADDR_W-1:2+WORD_BITS], {(WORD_BITS+2){1'b0}}};
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        cnt      <= cnt + WORD_BITS'(1);
                        mem_addr <= mem_addr + ADDR_W'(4);
                        if (last) begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wt.sv
// Directed bench for dcache_wt: backing-memory model with programmable ack
// delay, hand-computed expected data, request logging and stall counting.
module tb_dcache_wt;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_re;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    int          ack_delay = 0;
    int          wcnt = 0;
    int          n_wr = 0;
    int          stab_err = 0;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rd_log [$];
    logic [31:0] tbmem [logic [31:0]];

    dcache_wt dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Unwritten memory words read back as {C0DE, addr[15:0]}
    function automatic logic [31:0] memval(input logic [31:0] a);
        if (tbmem.exists(a))
            return tbmem[a];
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: each request waits ack_delay cycles, then acks for one cycle
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else begin
                if (wcnt == 0) begin
                    req_addr  = mem_addr;
                    req_wdata = mem_wdata;
                end else if (mem_addr !== req_addr || (mem_we && mem_wdata !== req_wdata)) begin
                    stab_err++;
                end
                if (wcnt == ack_delay) begin
                    mem_ack = 1'b1;
                    wcnt    = 0;
                    if (mem_we) begin
                        tbmem[mem_addr] = mem_wdata;
                        n_wr++;
                    end else begin
                        mem_rdata = memval(mem_addr);
                        rd_log.push_back(mem_addr);
                    end
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end
        end
    end

    // Called at posedge+1; holds the load until the cache stops stalling
    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d, output int st);
        bit done;
        done     = 1'b0;
        cpu_re   = 1'b1;
        cpu_addr = a;
        st       = 0;
        d        = '0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall) begin
                d    = cpu_rdata;
                done = 1'b1;
            end else begin
                st++;
            end
        end
        if (!done)
            chk("read_timeout", 32'(st), 32'd0);
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] wd, output int st);
        bit done;
        done      = 1'b0;
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = wd;
        st        = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!cpu_stall)
                done = 1'b1;
            else
                st++;
        end
        if (!done)
            chk("write_timeout", 32'(st), 32'd0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int          st;
        int          wr0;

        rst       = 1'b1;
        cpu_re    = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: cold read miss fills the whole line, then a neighbour hits
        rd_log.delete();
        cpu_read(32'h44, d, st);
        chk("t1_rdata", d, 32'hC0DE0044);
        chk("t1_stall", 32'(st), 32'd5);
        chk("t1_nreads", 32'(rd_log.size()), 32'd4);
        if (rd_log.size() == 4) begin
            chk("t1_addr0", rd_log[0], 32'h40);
            chk("t1_addr1", rd_log[1], 32'h44);
            chk("t1_addr2", rd_log[2], 32'h48);
            chk("t1_addr3", rd_log[3], 32'h4C);
        end
        cpu_read(32'h4C, d, st);
        chk("t1_hit_rdata", d, 32'hC0DE004C);
        chk("t1_hit_stall", 32'(st), 32'd0);

        // 2: store hit writes through and updates the cached word
        rd_log.delete();
        wr0 = n_wr;
        cpu_write(32'h44, 32'hDEADBEEF, st);
        chk("t2_wstall", 32'(st), 32'd1);
        chk("t2_nwr", 32'(n_wr - wr0), 32'd1);
        chk("t2_memword", memval(32'h44), 32'hDEADBEEF);
        cpu_read(32'h44, d, st);
        chk("t2_rdata", d, 32'hDEADBEEF);
        chk("t2_rstall", 32'(st), 32'd0);
        chk("t2_nreads", 32'(rd_log.size()), 32'd0);

        // 3: store miss does not allocate
        wr0 = n_wr;
        cpu_write(32'h200, 32'hCAFEF00D, st);
        chk("t3_nwr", 32'(n_wr - wr0), 32'd1);
        chk("t3_nreads_w", 32'(rd_log.size()), 32'd0);
        cpu_read(32'h200, d, st);
        chk("t3_rdata", d, 32'hCAFEF00D);
        chk("t3_nreads", 32'(rd_log.size()), 32'd4);
        chk("t3_stall", 32'(st), 32'd5);

        // 4: conflicting tag on index 4 evicts the old line
        cpu_read(32'h40, d, st);
        chk("t4_hit40_stall", 32'(st), 32'd0);
        chk("t4_hit40_rdata", d, 32'hC0DE0040);
        rd_log.delete();
        cpu_read(32'h440, d, st);
        chk("t4_rdata440", d, 32'hC0DE0440);
        chk("t4_nreads440", 32'(rd_log.size()), 32'd4);
        cpu_read(32'h40, d, st);
        chk("t4_evict_stall", 32'(st), 32'd5);

        // 5: reset in the middle of a refill
        cpu_read(32'h440, d, st);
        rd_log.delete();
        cpu_re   = 1'b1;
        cpu_addr = 32'h40;
        for (int i = 0; i < 100 && rd_log.size() < 2; i++)
            @(negedge clk);
        chk("t5_acks_seen", 32'(rd_log.size()), 32'd2);
        rst = 1'b1;
        #1;
        chk("t5_req_drop", 32'(mem_req), 32'd0);
        chk("t5_state", 32'(dut.state), 32'd0);
        cpu_re = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rd_log.delete();
        cpu_read(32'h40, d, st);
        chk("t5_nreads", 32'(rd_log.size()), 32'd4);
        chk("t5_rdata", d, 32'hC0DE0040);
        chk("t5_stall", 32'(st), 32'd5);
        if (rd_log.size() == 4) begin
            chk("t5_addr0", rd_log[0], 32'h40);
            chk("t5_addr3", rd_log[3], 32'h4C);
        end

        // 6: slow memory, three wait cycles before every ack
        ack_delay = 3;
        stab_err  = 0;
        rd_log.delete();
        cpu_read(32'h800, d, st);
        chk("t6_rstall", 32'(st), 32'd17);
        chk("t6_rdata", d, 32'hC0DE0800);
        chk("t6_nreads", 32'(rd_log.size()), 32'd4);
        cpu_write(32'h804, 32'h12345678, st);
        chk("t6_wstall", 32'(st), 32'd4);
        chk("t6_memword", memval(32'h804), 32'h12345678);
        cpu_read(32'h804, d, st);
        chk("t6_hit_rdata", d, 32'h12345678);
        chk("t6_hit_stall", 32'(st), 32'd0);
        chk("t6_stable", 32'(stab_err), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
